// File: rtl/feature_memory_nbank.sv
// Rotating N-bank feature memory: one bank takes writes while the others serve reads.
// Optional define FMEM_WR_GUARD_EN drops and flags write-side accesses made while not ready.
package graph_pkg;
  localparam int PRECISION = 8;
endpackage

module feature_memory_bank #(
  parameter int    DEPTH    = 1024,
  parameter int    AW       = 10,
  parameter int    DW       = 146,
  parameter string RAM_TYPE = "block"
) (
  input  logic          clk,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  input  logic          enb,
  input  logic          web,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dinb,
  output logic [DW-1:0] doutb
);
  if (RAM_TYPE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [DW-1:0] mem [DEPTH];
    // True dual-port memory with registered reads on both ports
    always_ff @(posedge clk) begin
      if (ena) begin
        if (wea) mem[addra] <= dina;
        else     douta <= mem[addra];
      end
      if (enb) begin
        if (web) mem[addrb] <= dinb;
        else     doutb <= mem[addrb];
      end
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];
    // True dual-port memory with registered reads on both ports
    always_ff @(posedge clk) begin
      if (ena) begin
        if (wea) mem[addra] <= dina;
        else     douta <= mem[addra];
      end
      if (enb) begin
        if (web) mem[addrb] <= dinb;
        else     doutb <= mem[addrb];
      end
    end
  end
endmodule

module feature_memory_nbank #(
  parameter int    GRAPH_SIZE  = 32,
  parameter int    PRECISION   = graph_pkg::PRECISION,
  parameter int    FEATURE_DIM = 16,
  parameter int    NUM_BANKS   = 3,
  parameter int    ADDR_WIDTH  = $clog2(GRAPH_SIZE*GRAPH_SIZE),
  parameter int    DATA_WIDTH  = FEATURE_DIM*PRECISION+18,
  parameter string RAM_TYPE    = "block"
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_ena,
  input  logic                                in_wea,
  input  logic [ADDR_WIDTH-1:0]               in_addr,
  input  logic [DATA_WIDTH-1:0]               in_write,
  output logic [DATA_WIDTH-1:0]               in_read,
  output logic                                in_ready,
  input  logic                                rotate_req,
  output logic                                rotate_ack,
  input  logic [ADDR_WIDTH-1:0]               out_addr,
  input  logic                                out_en,
  output logic [(NUM_BANKS-1)*DATA_WIDTH-1:0] out_read,
  output logic                                out_valid,
  output logic                                out_switch,
  output logic                                wr_err
);
  localparam int DEPTH = GRAPH_SIZE*GRAPH_SIZE;
  localparam int PTR_W = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {INIT = 2'd0, CLEAR = 2'd1, READY = 2'd2} state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] clear_addr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      in_ptr_r;
  logic                  rotate_ack_r;
  logic                  out_switch_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  out_live_r;
  logic                  in_live_r;
  logic [DATA_WIDTH-1:0] douta_s [NUM_BANKS];
  logic [DATA_WIDTH-1:0] doutb_s [NUM_BANKS];

  function automatic int slice_bank(input logic [PTR_W-1:0] ptr, input int k);
    return (int'(ptr) + NUM_BANKS - 1 - k) % NUM_BANKS;
  endfunction

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  ena_s;
    logic                  wea_s;
    logic [ADDR_WIDTH-1:0] addra_s;
    logic [DATA_WIDTH-1:0] dina_s;
    logic [DATA_WIDTH-1:0] douta_b_s;
    logic [DATA_WIDTH-1:0] doutb_b_s;

    // Port A steering: clear sweep owns the bank(s) being cleared, otherwise the write side
    always_comb begin
      ena_s   = 1'b0;
      wea_s   = 1'b0;
      addra_s = in_addr;
      dina_s  = in_write;
      if (state_r == INIT || (state_r == CLEAR && wr_ptr_r == PTR_W'(b))) begin
        ena_s   = 1'b1;
        wea_s   = 1'b1;
        addra_s = clear_addr_r;
        dina_s  = '0;
      end else if (state_r == READY && wr_ptr_r == PTR_W'(b)) begin
        ena_s = in_ena;
        wea_s = in_wea;
      end else begin
        ena_s = 1'b0;
        wea_s = 1'b0;
      end
    end

    feature_memory_bank #(
      .DEPTH(DEPTH), .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .RAM_TYPE(RAM_TYPE)
    ) u_bank (
      .clk(clk), .ena(ena_s), .wea(wea_s), .addra(addra_s), .dina(dina_s), .douta(douta_b_s),
      .enb(out_en), .web(1'b0), .addrb(out_addr), .dinb('0), .doutb(doutb_b_s)
    );

    assign douta_s[b] = douta_b_s;
    assign doutb_s[b] = doutb_b_s;
  end

  // Sweep / rotation controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= INIT;
      clear_addr_r <= '0;
      wr_ptr_r     <= '0;
      rotate_ack_r <= 1'b0;
      out_switch_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      case (state_r)
        INIT, CLEAR: begin
          rotate_ack_r <= 1'b0;
          out_switch_r <= 1'b0;
          if (clear_addr_r == ADDR_WIDTH'(DEPTH-1)) begin
            clear_addr_r <= '0;
            state_r      <= READY;
            in_ready_r   <= 1'b1;
          end else begin
            clear_addr_r <= clear_addr_r + ADDR_WIDTH'(1);
          end
        end
        READY: begin
          if (rotate_req) begin
            rotate_ack_r <= 1'b1;
            out_switch_r <= 1'b1;
            in_ready_r   <= 1'b0;
            state_r      <= CLEAR;
            wr_ptr_r     <= (wr_ptr_r == PTR_W'(NUM_BANKS-1)) ? '0 : wr_ptr_r + PTR_W'(1);
          end else begin
            rotate_ack_r <= 1'b0;
            out_switch_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= INIT;
          clear_addr_r <= '0;
          in_ready_r   <= 1'b0;
          rotate_ack_r <= 1'b0;
          out_switch_r <= 1'b0;
        end
      endcase
    end
  end

  // Bank mapping is captured with each read so a read straddling a rotation keeps old slices
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      rd_ptr_r    <= '0;
      out_live_r  <= 1'b0;
      in_ptr_r    <= '0;
      in_live_r   <= 1'b0;
    end else begin
      out_valid_r <= out_en;
      if (out_en) begin
        rd_ptr_r   <= wr_ptr_r;
        out_live_r <= 1'b1;
      end
      if (in_ready_r && in_ena && !in_wea) begin
        in_ptr_r  <= wr_ptr_r;
        in_live_r <= 1'b1;
      end
    end
  end

  // Bank read registers hold no reset value, so outputs are masked until the first read
  always_comb begin
    out_read = '0;
    in_read  = '0;
    if (out_live_r) begin
      for (int k = 0; k < NUM_BANKS-1; k++) begin
        out_read[k*DATA_WIDTH +: DATA_WIDTH] = doutb_s[slice_bank(rd_ptr_r, k)];
      end
    end else begin
      out_read = '0;
    end
    if (in_live_r) begin
      in_read = douta_s[in_ptr_r];
    end else begin
      in_read = '0;
    end
  end

  assign in_ready   = in_ready_r;
  assign rotate_ack = rotate_ack_r;
  assign out_valid  = out_valid_r;
  assign out_switch = out_switch_r;

`ifdef FMEM_WR_GUARD_EN
  logic wr_err_r;

  // Sticky flag for write-side accesses attempted while banks are being cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_r <= 1'b0;
    end else if (in_ena && !in_ready_r) begin
      wr_err_r <= 1'b1;
    end
  end

  assign wr_err = wr_err_r;
`else
  assign wr_err = 1'b0;
`endif
endmodule

// File: doc/feature_memory_nbank.md
FEATURE_MEMORY_NBANK -- requirements
Module: feature_memory_nbank

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  GRAPH_SIZE, 32, graph side length; bank depth DEPTH = GRAPH_SIZE*GRAPH_SIZE.
  PRECISION, graph_pkg::PRECISION, bits per feature.
  FEATURE_DIM, 16, features per node.
  NUM_BANKS, 3, rotating banks; legal range 3..8.
  ADDR_WIDTH, $clog2(DEPTH), address width.
  DATA_WIDTH, FEATURE_DIM*PRECISION+18, word width (features plus 9x2 edge bits).
  RAM_TYPE, "block", passed to each bank's memory instance.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock.
  reset  in  1  asynchronous, active-high reset.
  in_ena  in  1  write-side access enable.
  in_wea  in  1  write-side write enable.
  in_addr  in  ADDR_WIDTH  write-side address.
  in_write  in  DATA_WIDTH  write-side data.
  in_read  out  DATA_WIDTH  write-side read data.
  in_ready  out  1  write bank cleared; accesses accepted.
  rotate_req  in  1  request advance to the next bank; level, held until ack.
  rotate_ack  out  1  one-cycle pulse when the rotation is accepted.
  out_addr  in  ADDR_WIDTH  read-side address shared by all read ports.
  out_en  in  1  read-side enable.
  out_read  out  (NUM_BANKS-1)*DATA_WIDTH  slice k = bank (wr_ptr-1-k) mod NUM_BANKS; k=0 is newest.
  out_valid  out  1  out_read valid.
  out_switch  out  1  one-cycle pulse, first cycle after wr_ptr changes.
  wr_err  out  1  sticky write-guard error (see Configuration).

Function
REQ-003 The block SHALL instantiate NUM_BANKS dual-port memory instances; port A is write/clear, port B is read-only with web tied to 0.
REQ-004 The FSM SHALL have three states: INIT (clear all banks in parallel), CLEAR (clear the wr_ptr bank only), READY.
REQ-005 In INIT and CLEAR the FSM SHALL write zero at clear_addr = 0..DEPTH-1, one address per cycle, exactly DEPTH cycles, then enter READY.
REQ-006 in_ready SHALL be 1 only in READY.
REQ-007 In READY, in_ena/in_wea/in_addr/in_write SHALL drive port A of bank wr_ptr.
REQ-008 in_read SHALL present bank wr_ptr's data 1 cycle after an in_ena read.
REQ-009 When rotate_req=1 in READY, the block SHALL pulse rotate_ack, set wr_ptr <= (wr_ptr+1) mod NUM_BANKS, and enter CLEAR.
REQ-010 rotate_req asserted in INIT or CLEAR SHALL be held off without ack and accepted on the first READY cycle.
REQ-011 A write and rotate_req in the same READY cycle SHALL commit the write to the old bank.
REQ-012 out_valid SHALL equal out_en delayed 1 cycle.
REQ-013 out_read SHALL be registered bank data at out_addr, 1-cycle latency.
REQ-014 out_read SHALL be unaffected by CLEAR, since the cleared bank is never a read slice.
REQ-015 The read-bank mapping SHALL be sampled with the address, so a read straddling a rotation returns pre-rotation slices.
REQ-016 out_switch SHALL be 1 for exactly one cycle after each wr_ptr change.
REQ-017 Pointer arithmetic SHALL wrap modulo NUM_BANKS for non-power-of-2 values.

Reset
REQ-018 Asserting reset SHALL asynchronously set wr_ptr=0, clear_addr=0, state=INIT, rotate_ack=0, out_valid=0, out_switch=0, wr_err=0, in_ready=0, and in_read/out_read to 0.
REQ-019 Reset asserted mid-CLEAR or mid-INIT SHALL abort the sweep.
REQ-020 After reset release, INIT SHALL restart from address 0.

Configuration
REQ-021 With FMEM_WR_GUARD_EN defined, in_ena while in_ready=0 SHALL be dropped (no bank write) and SHALL set wr_err until reset.
REQ-022 Without FMEM_WR_GUARD_EN, wr_err SHALL be tied 0 and in_ena while in_ready=0 SHALL be ignored.

Verification (NUM_BANKS=4, GRAPH_SIZE=4, DEPTH=16)
REQ-023 Release reset -> in_ready rises after exactly 16 cycles, and all banks read 0 at addresses 0..15.
REQ-024 Write 0xA5 at address 3, then pulse rotate_req -> rotate_ack and out_switch each pulse once, in_ready is low 16 cycles, and out_read slice0 at address 3 = 0xA5.
REQ-025 Perform 4 rotations writing tags 1..4 -> wr_ptr wraps to 0, slices 0..2 hold tags 4,3,2, and bank 0 reads 0.
REQ-026 Assert rotate_req during CLEAR -> no ack until READY, then ack on the first READY cycle.
REQ-027 Assert reset at clear_addr=7 -> outputs reach reset values immediately, and INIT runs the full 16 cycles.
REQ-028 With FMEM_WR_GUARD_EN, write during CLEAR -> wr_err=1 and the bank stays 0; without the macro, wr_err stays 0.
